shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
- Sequential unsigned 6x6 shift-and-add multiplier producing a 12-bit product.
- Does not contain its own adder. It drives the operand and carry-in inputs of the external 12-bit ripple-carry adder and captures the adder's sum and carry-out every cycle.
- Sits directly around the adder: it feeds the adder and consumes the adder's result.
- Used as the multiply unit; fixed, data-independent latency.

Parameters:
- WIDTH, 6, operand width. Product/adder width is 2*WIDTH = 12. Only 6 is supported, to match the 12-bit adder.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request; sampled at a rising edge when not busy
- multiplicand  input  6  unsigned operand A; sampled with an accepted start
- multiplier  input  6  unsigned operand B; sampled with an accepted start
- add_a  output  12  to adder in1: accumulator value
- add_b  output  12  to adder in2: shifted multiplicand when the current multiplier LSB is 1, else 0
- add_cin  output  1  to adder cin: constant 0
- add_sum  input  12  from adder sum
- add_cout  input  1  from adder cout
- busy  output  1  high while the multiply is in progress
- done  output  1  one-cycle pulse, product valid
- product  output  12  last completed result; holds until the next completion
- adder_err  output  1  sticky flag: adder carry-out seen during an operation

Behaviour:
- Reset (resetn low, asynchronous, takes effect immediately regardless of clock):
  - state=IDLE.
  - Accumulator, shift registers, count, product all 0.
  - busy=0, done=0, adder_err=0.
  - An operation in flight is abandoned; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, then load mcand_reg={6'b0,multiplicand}, mplr_reg=multiplier, acc=0, count=0, adder_err=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: add_a=acc; add_b = mplr_reg[0] ? mcand_reg : 0. At each edge:
    - acc <= add_sum
    - mcand_reg <= mcand_reg<<1 (logical, 12-bit)
    - mplr_reg <= mplr_reg>>1 (logical)
    - count <= count+1
    - if add_cout=1, set adder_err
  - RUN exit: on the edge where count==5 (the 6th accumulation), product <= add_sum and go to DONE.
  - DONE: done=1 for exactly this one cycle. If start=1 at the edge, accept it exactly as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
- Outputs by state:
  - busy=1 only in RUN.
  - done=1 only in DONE.
  - In IDLE and DONE: add_a=0 and add_b=0.
  - add_cin=0 at all times.
- start while in RUN is ignored; operands are not resampled and the operation completes unchanged.
- Operands are captured only on acceptance; later input changes have no effect.
- Latency: start accepted at edge E0 → RUN during cycles after edges E0..E5 → product loaded and done high after edge E6. Exactly 7 clock edges from acceptance to done. Throughput is one multiply per 7 cycles with back-to-back starts.
- Width: 63*63=3969 fits in 12 bits, so add_cout is always 0 for a correct adder. adder_err exists solely to detect adder faults. It is sticky until the next accepted start or reset.
- The add_sum → acc path is combinational through the external adder within one cycle. There is no combinational path from add_sum to any output of this block.
- product changes only on the RUN→DONE edge or on reset.

Test Plan:
- Reset: assert resetn=0 mid-cycle with no clock edge → product=0, busy=0, done=0, adder_err=0, add_a=0, add_b=0 immediately.
- Basic: start with 5*3 → busy high for 6 cycles, done pulse on the 7th edge, product=15 (0x00F), adder_err=0.
- Extremes:
  - 63*63 → product=3969 (0xF81).
  - 0*63 → 0.
  - 63*1 → 63.
  - add_b is 0 in every RUN cycle whose multiplier bit is 0.
- Back-to-back and ignored start:
  - start held high continuously with 7*9 then 12*10 → done pulses 7 cycles apart, products 63 then 120.
  - start pulsed during RUN with different operands → ignored, first product unchanged.
- Reset mid-operation: resetn low at the 3rd RUN cycle of 20*20 → immediate return to IDLE with product=0, no done pulse; a subsequent 2*2 yields 4.
- Adder fault: replace the adder with a model forcing add_cout=1 on one cycle → adder_err=1 after that edge and held through done; next accepted start clears it to 0.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier that drives an external
// 2*WIDTH-bit ripple-carry adder and accumulates its sum once per cycle.
module shift_add_mult #(
  parameter int WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   add_a,
  output logic [2*WIDTH-1:0]   add_b,
  output logic                 add_cin,
  input  logic [2*WIDTH-1:0]   add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 adder_err
);

  localparam int PW = 2 * WIDTH;
  localparam logic [2:0] LAST = 3'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [2:0]      count_q, count_d;
  logic [PW-1:0]   product_q, product_d;
  logic            err_q, err_d;

  logic            accept;
  logic            last_step;

  // A new request is taken from IDLE or straight out of DONE (back-to-back).
  assign accept    = start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (count_q == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      count_q   <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      count_q   <= count_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = last_step ? DONE : RUN;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    count_d   = count_q;
    product_d = product_q;
    err_d     = err_q;
    if (accept) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, multiplicand};
      mplr_d  = multiplier;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == RUN) begin
      acc_d   = add_sum;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      count_d = count_q + 3'd1;
      // A correct adder never carries out here, so any carry marks a faulty adder.
      if (add_cout) err_d = 1'b1;
      if (last_step) product_d = add_sum;
    end
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    add_cin = 1'b0;
    add_a   = busy ? acc_q : '0;
    add_b   = (busy && mplr_q[0]) ? mcand_q : '0;
  end

  assign product   = product_q;
  assign adder_err = err_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult with a behavioural adder and a
// product/partial-sum reference model computed with plain integer arithmetic.
module tb_shift_add_mult;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [5:0]  multiplicand;
  logic [5:0]  multiplier;
  logic [11:0] add_a;
  logic [11:0] add_b;
  logic        add_cin;
  logic [11:0] add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [11:0] product;
  logic        adder_err;

  logic        fault_cout;
  logic [12:0] adder_full;

  int n_checks;
  int n_fail;

  shift_add_mult #(.WIDTH(6)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .adder_err    (adder_err)
  );

  // External adder, with an injectable carry-out fault.
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {12'd0, add_cin};
  assign add_sum    = adder_full[11:0];
  assign add_cout   = adder_full[12] | fault_cout;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic run_mult(input logic [5:0] a, input logic [5:0] b,
                          output logic [11:0] p, output int edges,
                          output int busy_cyc, output bit timed_out);
    @(negedge clock);
    start = 1'b1; multiplicand = a; multiplier = b;
    edges = 0; busy_cyc = 0; timed_out = 1'b1; p = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
      multiplicand = 6'($urandom);
      multiplier   = 6'($urandom);
      if (busy) busy_cyc++;
      if (done) begin
        timed_out = 1'b0;
        p = product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [11:0] p; int e, bc; bit to;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 12'd0 || adder_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b product=%h err=%b, required 0 0 000 0",
               busy, done, product, adder_err);
    end
    resetn = 1'b1;
    run_mult(6'd13, 6'd11, p, e, bc, to);
    n_checks++;
    if (to || p !== 12'd143) begin
      n_fail++;
      $display("FAIL reset_pre_op: product=%0d timeout=%0d, required 143", p, to);
    end
    // Put an operation in flight, then assert reset between clock edges.
    @(negedge clock); start = 1'b1; multiplicand = 6'd9; multiplier = 6'd7;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 12'd0 || adder_err !== 1'b0 ||
        add_a !== 12'd0 || add_b !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b product=%h err=%b add_a=%h add_b=%h, required all 0",
               busy, done, product, adder_err, add_a, add_b);
    end
    @(negedge clock); resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [11:0] p; int e, bc; bit to;
    run_mult(6'd5, 6'd3, p, e, bc, to);
    n_checks++;
    if (to || p !== 12'h00F) begin
      n_fail++;
      $display("FAIL basic_product: got %h timeout=%0d, required 00f", p, to);
    end
    n_checks++;
    if (e !== 7) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d edges, required 7", e);
    end
    n_checks++;
    if (bc !== 6) begin
      n_fail++;
      $display("FAIL basic_busy: busy for %0d cycles, required 6", bc);
    end
    n_checks++;
    if (adder_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: adder_err=%b, required 0", adder_err);
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 12'h00F) begin
      n_fail++;
      $display("FAIL basic_after: done=%b busy=%b product=%h, required 0 0 00f", done, busy, product);
    end
  endtask

  task automatic test_random();
    logic [11:0] p; int e, bc; bit to;
    logic [5:0] a, b;
    for (int i = 0; i < 25; i++) begin
      a = 6'($urandom); b = 6'($urandom);
      run_mult(a, b, p, e, bc, to);
      n_checks++;
      if (to || p !== 12'(int'(a) * int'(b)) || e !== 7 || bc !== 6 || adder_err !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: %0d*%0d got %0d edges=%0d busy=%0d err=%b, required %0d 7 6 0",
                 i, a, b, p, e, bc, adder_err, int'(a) * int'(b));
      end
    end
  endtask

  task automatic test_extremes();
    logic [11:0] p; int e, bc; bit to;
    logic [5:0] av [3] = '{6'd63, 6'd0, 6'd63};
    logic [5:0] bv [3] = '{6'd63, 6'd63, 6'd1};
    int         pv [3] = '{3969, 0, 63};
    for (int i = 0; i < 3; i++) begin
      run_mult(av[i], bv[i], p, e, bc, to);
      n_checks++;
      if (to || p !== 12'(pv[i]) || e !== 7) begin
        n_fail++;
        $display("FAIL extreme_%0d: %0d*%0d got %0d edges=%0d, required %0d 7",
                 i, av[i], bv[i], p, e, pv[i]);
      end
    end
  endtask

  task automatic test_adder_ports();
    logic [5:0] av [3] = '{6'd63, 6'd37, 6'd21};
    logic [5:0] bv [3] = '{6'b101010, 6'b010001, 6'b000000};
    int exp_a, exp_b;
    for (int v = 0; v < 3; v++) begin
      @(negedge clock);
      start = 1'b1; multiplicand = av[v]; multiplier = bv[v];
      @(posedge clock);
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        start = 1'b0;
        multiplicand = 6'($urandom); multiplier = 6'($urandom);
        exp_a = int'(av[v]) * (int'(bv[v]) % (1 << i));
        exp_b = bv[v][i] ? int'(av[v]) << i : 0;
        n_checks++;
        if (busy !== 1'b1 || add_a !== 12'(exp_a) || add_b !== 12'(exp_b) || add_cin !== 1'b0) begin
          n_fail++;
          $display("FAIL ports_v%0d_c%0d: busy=%b add_a=%h add_b=%h cin=%b, required 1 %h %h 0",
                   v, i, busy, add_a, add_b, add_cin, 12'(exp_a), 12'(exp_b));
        end
        @(posedge clock);
      end
      @(negedge clock);
      n_checks++;
      if (done !== 1'b1 || product !== 12'(int'(av[v]) * int'(bv[v])) ||
          add_a !== 12'd0 || add_b !== 12'd0) begin
        n_fail++;
        $display("FAIL ports_v%0d_done: done=%b product=%0d add_a=%h add_b=%h, required 1 %0d 0 0",
                 v, done, product, add_a, add_b, int'(av[v]) * int'(bv[v]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic [11:0] p1, p2;
    t1 = -1; t2 = -1; p1 = '0; p2 = '0;
    @(negedge clock);
    start = 1'b1; multiplicand = 6'd7; multiplier = 6'd9;
    @(posedge clock);
    @(negedge clock);
    multiplicand = 6'd12; multiplier = 6'd10;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        if (t1 < 0) begin
          t1 = k; p1 = product;
        end else begin
          t2 = k; p2 = product;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (t1 !== 6 || p1 !== 12'd63) begin
      n_fail++;
      $display("FAIL b2b_first: done at %0d product=%0d, required 6 63", t1, p1);
    end
    n_checks++;
    if (t2 - t1 !== 7 || p2 !== 12'd120) begin
      n_fail++;
      $display("FAIL b2b_second: spacing=%0d product=%0d, required 7 120", t2 - t1, p2);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_ignored_start();
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    start = 1'b1; multiplicand = 6'd5; multiplier = 6'd6;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1; multiplicand = 6'd9; multiplier = 6'd9;
    @(negedge clock); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || product !== 12'd30) begin
      n_fail++;
      $display("FAIL ignored_start: product=%0d seen=%0d, required 30", product, seen);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_queue: busy=%b after done, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] p; int e, bc; bit to;
    bit spurious;
    spurious = 1'b0;
    @(negedge clock);
    start = 1'b1; multiplicand = 6'd20; multiplier = 6'd20;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b product=%0d, required 0 0 0", busy, done, product);
    end
    @(negedge clock); resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done || busy) spurious = 1'b1;
    end
    n_checks++;
    if (spurious) begin
      n_fail++;
      $display("FAIL reset_mid_abandon: activity after reset, required none");
    end
    run_mult(6'd2, 6'd2, p, e, bc, to);
    n_checks++;
    if (to || p !== 12'd4) begin
      n_fail++;
      $display("FAIL reset_mid_next: product=%0d, required 4", p);
    end
  endtask

  task automatic test_adder_fault();
    logic [11:0] p; int e, bc; bit to;
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    start = 1'b1; multiplicand = 6'd6; multiplier = 6'd7;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (adder_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_before: adder_err=%b, required 0", adder_err);
    end
    fault_cout = 1'b1;
    @(posedge clock);
    @(negedge clock);
    fault_cout = 1'b0;
    n_checks++;
    if (adder_err !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_set: adder_err=%b, required 1", adder_err);
    end
    for (int k = 0; k < 20; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    n_checks++;
    if (!seen || adder_err !== 1'b1 || product !== 12'd42) begin
      n_fail++;
      $display("FAIL fault_hold: seen=%0d adder_err=%b product=%0d, required 1 1 42", seen, adder_err, product);
    end
    @(negedge clock);
    start = 1'b1; multiplicand = 6'd3; multiplier = 6'd3;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    n_checks++;
    if (adder_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: adder_err=%b, required 0", adder_err);
    end
    run_mult(6'd1, 6'd1, p, e, bc, to);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    resetn = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0; fault_cout = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_extremes();
    test_adder_ports();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_adder_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
